// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector with configurable pattern, length, overlap mode and
// Mealy/registered-Moore output, plus sample enable, synchronous clear and saturating match counter.
module seq_pattern_detector #(
    parameter int unsigned      LEN     = 3,
    parameter logic [LEN-1:0]   PATTERN = 3'b101,
    parameter bit               OVERLAP = 1'b1,
    parameter bit               MEALY   = 1'b1,
    parameter int unsigned      COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    input  logic               clear,
    input  logic               x,
    output logic               match,
    output logic [COUNT_W-1:0] match_count
);

    localparam int unsigned        HW        = LEN - 1;
    localparam int unsigned        FW        = $clog2(LEN);
    localparam logic [FW-1:0]      FILL_FULL = FW'(LEN - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX   = {COUNT_W{1'b1}};

    if (LEN < 2 || LEN > 16) begin : g_bad_len
        $error("seq_pattern_detector: LEN must be in 2..16");
    end
    if (COUNT_W < 1) begin : g_bad_count_w
        $error("seq_pattern_detector: COUNT_W must be at least 1");
    end

    logic [HW-1:0]      hist, hist_d;
    logic [FW-1:0]      fill, fill_d;
    logic [COUNT_W-1:0] cnt, cnt_d;
    logic               hit;

    // A match needs a full history window plus the incoming bit; clear suppresses it.
    assign hit = en & ~clear & (fill == FILL_FULL) & ({hist, x} == PATTERN);

    // Next-state: clear beats enable, enable beats hold.
    always_comb begin
        hist_d = hist;
        fill_d = fill;
        cnt_d  = cnt;
        if (clear) begin
            hist_d = '0;
            fill_d = '0;
            cnt_d  = '0;
        end else if (en) begin
            if (hit && !OVERLAP) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                // Truncating {hist,x} keeps the newest LEN-1 bits, which also covers LEN=2.
                hist_d = HW'({hist, x});
                if (fill != FILL_FULL) begin
                    fill_d = fill + FW'(1);
                end
            end
            if (hit && cnt != CNT_MAX) begin
                cnt_d = cnt + COUNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist <= '0;
            fill <= '0;
            cnt  <= '0;
        end else begin
            hist <= hist_d;
            fill <= fill_d;
            cnt  <= cnt_d;
        end
    end

    assign match_count = cnt;

    if (MEALY) begin : g_mealy
        assign match = hit;
    end else begin : g_moore
        logic match_r;

        // hit is already zero under clear or en=0, so the pulse is exactly one cycle wide.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                match_r <= 1'b0;
            end else begin
                match_r <= hit;
            end
        end

        assign match = match_r;
    end

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed bench for seq_pattern_detector: several parameterisations share one input stream,
// each scenario checks the instance it targets against hand-computed values.
module tb_seq_pattern_detector;

    logic clk = 1'b0;
    logic reset_n;
    logic en;
    logic clear;
    logic x;

    int total = 0;
    int bad   = 0;

    logic       d_m,   nov_m,   mo_m,   l8_m,   sat_m;
    logic [7:0] d_cnt, nov_cnt, mo_cnt, l8_cnt;
    logic [1:0] sat_cnt;

    always #5 clk = ~clk;

    seq_pattern_detector u_dflt (
        .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .x(x),
        .match(d_m), .match_count(d_cnt)
    );

    seq_pattern_detector #(.OVERLAP(1'b0)) u_nov (
        .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .x(x),
        .match(nov_m), .match_count(nov_cnt)
    );

    seq_pattern_detector #(.MEALY(1'b0)) u_moore (
        .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .x(x),
        .match(mo_m), .match_count(mo_cnt)
    );

    seq_pattern_detector #(.LEN(8), .PATTERN(8'hA5)) u_len8 (
        .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .x(x),
        .match(l8_m), .match_count(l8_cnt)
    );

    seq_pattern_detector #(.COUNT_W(2)) u_sat (
        .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .x(x),
        .match(sat_m), .match_count(sat_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one sample mid-low-phase; outputs are sampled 2ns later, well before the next rising edge.
    task automatic step(input logic xv, input logic ev, input logic cv);
        @(negedge clk);
        x     = xv;
        en    = ev;
        clear = cv;
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        en      = 1'b0;
        clear   = 1'b0;
        x       = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [7:0] pat8;
        logic       sat_exp_m [10];
        int         sat_exp_c [10];

        // Reset state
        reset_n = 1'b0;
        en      = 1'b0;
        clear   = 1'b0;
        x       = 1'b1;
        #12;
        chk("rst_d_match", 32'(d_m), 0);
        chk("rst_d_cnt",   32'(d_cnt), 0);
        chk("rst_mo_match", 32'(mo_m), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Scenarios 1-3: 1,0,1,0,1,0,1 then idle cycles
        step(1, 1, 0); chk("s1_d", 32'(d_m), 0); chk("s1_nov", 32'(nov_m), 0); chk("s1_mo", 32'(mo_m), 0);
        step(0, 1, 0); chk("s2_d", 32'(d_m), 0); chk("s2_mo", 32'(mo_m), 0);
        step(1, 1, 0); chk("s3_d", 32'(d_m), 1); chk("s3_nov", 32'(nov_m), 1); chk("s3_mo", 32'(mo_m), 0);
        step(0, 1, 0); chk("s4_d", 32'(d_m), 0); chk("s4_nov", 32'(nov_m), 0); chk("s4_mo", 32'(mo_m), 1);
        chk("s4_d_cnt", 32'(d_cnt), 1);
        step(1, 1, 0); chk("s5_d", 32'(d_m), 1); chk("s5_nov", 32'(nov_m), 0); chk("s5_mo", 32'(mo_m), 0);
        step(0, 1, 0); chk("s6_d", 32'(d_m), 0); chk("s6_nov", 32'(nov_m), 0); chk("s6_mo", 32'(mo_m), 1);
        chk("s6_d_cnt", 32'(d_cnt), 2); chk("s6_nov_cnt", 32'(nov_cnt), 1);
        step(1, 1, 0); chk("s7_d", 32'(d_m), 1); chk("s7_nov", 32'(nov_m), 1); chk("s7_mo", 32'(mo_m), 0);
        step(0, 0, 0); chk("s8_d", 32'(d_m), 0); chk("s8_mo", 32'(mo_m), 1);
        chk("s8_d_cnt", 32'(d_cnt), 3); chk("s8_nov_cnt", 32'(nov_cnt), 2);
        chk("s8_mo_cnt", 32'(mo_cnt), 3); chk("s8_sat_cnt", 32'(sat_cnt), 3);
        step(0, 0, 0); chk("s9_mo", 32'(mo_m), 0);

        // Scenario 4: LEN=8 pattern A5 with en gaps; disabled cycles carry the inverted bit
        do_reset();
        pat8 = 8'hA5;
        for (int j = 0; j < 8; j++) begin
            step(pat8[7-j], 1, 0);
            chk($sformatf("l8_on%0d", j), 32'(l8_m), (j == 7) ? 1 : 0);
            step(~pat8[7-j], 0, 0);
            chk($sformatf("l8_off%0d", j), 32'(l8_m), 0);
        end
        chk("l8_cnt", 32'(l8_cnt), 1);

        // Scenario 5: COUNT_W=2 saturation on 1010101010
        do_reset();
        sat_exp_m = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 0};
        sat_exp_c = '{0, 0, 0, 1, 1, 2, 2, 3, 3, 3};
        for (int i = 0; i < 10; i++) begin
            step((i % 2 == 0) ? 1'b1 : 1'b0, 1, 0);
            chk($sformatf("sat_m%0d", i + 1), 32'(sat_m), 32'(sat_exp_m[i]));
            chk($sformatf("sat_c%0d", i + 1), 32'(sat_cnt), 32'(sat_exp_c[i]));
        end
        step(0, 0, 0);
        chk("sat_hold", 32'(sat_cnt), 3);
        chk("sat_d_cnt", 32'(d_cnt), 4);

        // Scenario 6a: asynchronous reset mid-pattern
        do_reset();
        step(1, 1, 0); step(0, 1, 0);
        step(1, 1, 0); chk("r6_hit", 32'(d_m), 1);
        step(0, 1, 0); chk("r6_cnt1", 32'(d_cnt), 1);
        step(1, 1, 0); chk("r6_pre", 32'(d_m), 1);
        #1 reset_n = 1'b0;
        #1;
        chk("r6_async_m", 32'(d_m), 0);
        chk("r6_async_c", 32'(d_cnt), 0);
        chk("r6_async_mo", 32'(mo_m), 0);
        @(negedge clk);
        reset_n = 1'b1;
        step(1, 1, 0); chk("r6_after", 32'(d_m), 0);
        step(0, 0, 0); chk("r6_after_c", 32'(d_cnt), 0);

        // Scenario 6b: clear on the final bit discards the hit
        do_reset();
        step(1, 1, 0); step(0, 1, 0);
        step(1, 1, 1); chk("c6_d", 32'(d_m), 0); chk("c6_nov", 32'(nov_m), 0);
        step(0, 1, 0); chk("c6_cnt", 32'(d_cnt), 0); chk("c6_mo", 32'(mo_m), 0);
        step(1, 1, 0); chk("c6_refill", 32'(d_m), 0);
        step(0, 1, 0); chk("c6_refill2", 32'(d_m), 0);
        step(1, 1, 0); chk("c6_resume", 32'(d_m), 1);
        step(0, 0, 0); chk("c6_resume_c", 32'(d_cnt), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
